// File: rtl/clk_sel_ctrl_if.sv
// -----------------------------------------------------------------------------
// clk_sel_ctrl_if
//   Signal bundle between the clock-select controller and its environment.
//   master : environment side (drives heartbeats and the request, reads status)
//   slave  : controller side
//
//   hb1, hb2   heartbeat toggles from the clk1/clk2 domains (async to clk)
//   req_clk1   requested source, 1 = clk1, 0 = clk2
//   auto_en    enable automatic failover away from a dead source
//   sel_clk1   registered select to the glitch-free clock switch
//   busy       settle hold-off in progress
//   clk1_ok    clk1 heartbeat alive
//   clk2_ok    clk2 heartbeat alive
//   both_dead  neither heartbeat alive
//   failover   one-cycle pulse when auto mode picks the non-requested source
// -----------------------------------------------------------------------------
interface clk_sel_ctrl_if;
    logic hb1;
    logic hb2;
    logic req_clk1;
    logic auto_en;
    logic sel_clk1;
    logic busy;
    logic clk1_ok;
    logic clk2_ok;
    logic both_dead;
    logic failover;

    modport master (
        output hb1, hb2, req_clk1, auto_en,
        input  sel_clk1, busy, clk1_ok, clk2_ok, both_dead, failover
    );

    modport slave (
        input  hb1, hb2, req_clk1, auto_en,
        output sel_clk1, busy, clk1_ok, clk2_ok, both_dead, failover
    );
endinterface

// File: rtl/clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// clk_sel_ctrl
//   Control stage ahead of the glitch-free clock switch. Produces the switch's
//   registered select (1 = clk1, 0 = clk2), honouring the requested source,
//   holding the select stable for SETTLE cycles after every change and, in
//   auto mode, failing over away from a source whose heartbeat has stopped.
//
//   Ports:
//     clk  free-running reference clock, all logic on its rising edge
//     rst  asynchronous active-high reset
//     bus  clk_sel_ctrl_if.slave (heartbeats, request, select and status)
//
//   clk_sel_wdog (same file) is the per-source heartbeat synchronizer and
//   watchdog; one instance per clock source.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// clk_sel_wdog
//   Synchronizes one heartbeat toggle, turns every edge of it into a beat and
//   flags the source dead after TIMEOUT clk cycles without a beat.
//
//   Ports:
//     clk, rst  reference clock / async active-high reset
//     hb        heartbeat toggle, asynchronous to clk
//     ok        registered alive flag, 1 while the watchdog count < TIMEOUT
// -----------------------------------------------------------------------------
module clk_sel_wdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic hb,
    output logic ok
);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // sync[0..1] form the synchronizer, sync[2] is the edge-detect history
    logic [2:0]       sync;
    logic             beat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], hb};
        end
    end

    // Toggle protocol: rising and falling edges both count as a beat
    assign beat = sync[1] ^ sync[2];

    always_comb begin
        cnt_nxt = cnt;
        if (beat) begin
            cnt_nxt = '0;
        end else if (cnt < TMO) begin
            cnt_nxt = cnt + ONE;
        end
    end

    // ok is registered from the next count so it tracks (cnt < TIMEOUT)
    // on the same edge the count changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ok  <= 1'b1;
        end else begin
            cnt <= cnt_nxt;
            ok  <= (cnt_nxt < TMO);
        end
    end
endmodule

module clk_sel_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int SETTLE  = 16,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst,
    clk_sel_ctrl_if.slave  bus
);
    localparam int               NUM_SRC  = 2;
    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_CLK1 = 2'd0,
        S_HOLD = 2'd1,
        S_CLK2 = 2'd2
    } state_t;

    // ---------------------------------------------------------------- watchdogs
    // index 0 = clk1, index 1 = clk2
    logic [NUM_SRC-1:0] hb_vec;
    logic [NUM_SRC-1:0] ok_vec;

    assign hb_vec = {bus.hb2, bus.hb1};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_wdog
        clk_sel_wdog #(
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_wdog (
            .clk (clk),
            .rst (rst),
            .hb  (hb_vec[i]),
            .ok  (ok_vec[i])
        );
    end

    logic ok1;
    logic ok2;
    assign ok1 = ok_vec[0];
    assign ok2 = ok_vec[1];

    // ---------------------------------------------------------------- FSM state
    state_t           state, state_nxt;
    logic             sel, sel_nxt;
    logic             busy, busy_nxt;
    logic             fo, fo_nxt;
    logic [CNT_W-1:0] scnt, scnt_nxt;
    logic             want;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_CLK1;
            sel   <= 1'b1;
            busy  <= 1'b0;
            fo    <= 1'b0;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            busy  <= busy_nxt;
            fo    <= fo_nxt;
            scnt  <= scnt_nxt;
        end
    end

    // Target source. In auto mode the requested source wins while alive, the
    // other one is taken if only it is alive, and with both dead we stay put.
    // Manual mode follows the request even onto a dead clock.
    always_comb begin
        want = sel;
        if (!bus.auto_en) begin
            want = bus.req_clk1;
        end else if (bus.req_clk1) begin
            if (ok1)      want = 1'b1;
            else if (ok2) want = 1'b0;
        end else begin
            if (ok2)      want = 1'b0;
            else if (ok1) want = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        busy_nxt  = busy;
        fo_nxt    = 1'b0;
        scnt_nxt  = scnt;
        case (state)
            S_CLK1, S_CLK2: begin
                if (want != sel) begin
                    sel_nxt   = want;
                    scnt_nxt  = SETTLE_M1;
                    busy_nxt  = 1'b1;
                    state_nxt = S_HOLD;
                    fo_nxt    = bus.auto_en && (want != bus.req_clk1);
                end
            end
            S_HOLD: begin
                // Inputs are deliberately ignored here; a request that moved
                // during the hold is picked up on the first edge after exit.
                if (scnt == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = sel ? S_CLK1 : S_CLK2;
                end else begin
                    scnt_nxt = scnt - ONE;
                end
            end
            default: begin
                state_nxt = S_CLK1;
                sel_nxt   = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    assign bus.sel_clk1  = sel;
    assign bus.busy      = busy;
    assign bus.failover  = fo;
    assign bus.clk1_ok   = ok1;
    assign bus.clk2_ok   = ok2;
    assign bus.both_dead = !ok1 && !ok2;
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_sel_ctrl
//   Directed bench for clk_sel_ctrl. Each step pushes the expected values of
//   named outputs onto a scoreboard queue as it drives stimulus; the queue is
//   drained against the DUT outputs #1 after the next rising edge(s).
// -----------------------------------------------------------------------------
module tb_clk_sel_ctrl;
    logic clk;
    logic rst;

    clk_sel_ctrl_if bus ();

    clk_sel_ctrl #(
        .TIMEOUT (64),
        .SETTLE  (16),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string tag;
        logic  val;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic hb1_run  = 1'b1;
    logic hb2_run  = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running heartbeats, both well inside the 64-cycle timeout.
    // Toggles land 2 time units after the edge, away from the main sequence.
    initial begin
        int hcyc;
        hcyc    = 0;
        bus.hb1 = 1'b0;
        bus.hb2 = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            hcyc++;
            if (hb1_run && (hcyc % 8 == 0)) bus.hb1 = ~bus.hb1;
            if (hb2_run && (hcyc % 6 == 3)) bus.hb2 = ~bus.hb2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic val);
        sb_q.push_back('{tag, val});
    endtask

    function automatic logic observe(input string tag);
        case (tag)
            "sel":  return bus.sel_clk1;
            "busy": return bus.busy;
            "fo":   return bus.failover;
            "ok1":  return bus.clk1_ok;
            "ok2":  return bus.clk2_ok;
            "bd":   return bus.both_dead;
            default: return 1'bx;
        endcase
    endfunction

    task automatic drain(input string step);
        exp_t e;
        logic o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.tag);
            checks++;
            assert (o === e.val) else begin
                failures++;
                $error("FAIL %s.%s observed=%b expected=%b", step, e.tag, o, e.val);
            end
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.req_clk1 = 1'b1;
        bus.auto_en  = 1'b0;

        // ---- reset with heartbeats toggling
        tick(5);
        push("sel", 1); push("busy", 0); push("fo", 0);
        push("ok1", 1); push("ok2", 1); push("bd", 0);
        drain("in_reset");
        rst = 1'b0;
        tick(3);
        push("sel", 1); push("busy", 0); push("fo", 0);
        push("ok1", 1); push("ok2", 1); push("bd", 0);
        drain("after_reset");

        // ---- manual switch, request flips back during the hold
        bus.req_clk1 = 1'b0;                       // cycle 0
        push("sel", 0); push("busy", 1); push("fo", 0);
        tick(1); drain("man_sw");                  // edge 1
        tick(4);
        bus.req_clk1 = 1'b1;                       // cycle 5, inside hold
        push("sel", 0); push("busy", 1);
        tick(11); drain("man_hold_last");          // edge 16
        push("sel", 0); push("busy", 0);
        tick(1); drain("man_hold_exit");           // edge 17
        push("sel", 1); push("busy", 1); push("fo", 0);
        tick(1); drain("man_reeval");              // edge 18
        push("busy", 1);
        tick(15); drain("man_hold2_last");         // edge 33
        push("busy", 0); push("sel", 1);
        tick(1); drain("man_hold2_exit");          // edge 34

        // ---- watchdog on clk2: last beat from a known toggle
        hb2_run = 1'b0;
        tick(2);
        bus.hb2 = ~bus.hb2;
        push("ok2", 1); push("bd", 0);
        tick(66); drain("wd_before_to");
        push("ok2", 0); push("ok1", 1); push("bd", 0); push("sel", 1);
        tick(1); drain("wd_timeout");
        bus.hb2 = ~bus.hb2;
        push("ok2", 0);
        tick(2); drain("wd_revive_early");
        push("ok2", 1);
        tick(1); drain("wd_revive");
        hb2_run = 1'b1;

        // ---- auto mode, move to clk2 then lose it
        bus.auto_en  = 1'b1;
        bus.req_clk1 = 1'b0;
        push("sel", 0); push("busy", 1); push("fo", 0);
        tick(1); drain("auto_to_clk2");
        push("sel", 0); push("busy", 0);
        tick(20); drain("auto_on_clk2");
        hb2_run = 1'b0;
        tick(2);
        bus.hb2 = ~bus.hb2;
        push("ok2", 0); push("sel", 0); push("fo", 0);
        tick(67); drain("fo_ok_fall");
        push("sel", 1); push("fo", 1); push("busy", 1);
        tick(1); drain("fo_switch");
        push("fo", 0); push("busy", 1); push("sel", 1);
        tick(1); drain("fo_pulse_end");
        push("busy", 1);
        tick(14); drain("fo_hold_last");
        push("busy", 0); push("sel", 1);
        tick(1); drain("fo_hold_exit");
        bus.hb2 = ~bus.hb2;
        push("ok2", 1); push("sel", 1);
        tick(3); drain("fo_revive_ok");
        push("sel", 0); push("fo", 0); push("busy", 1);
        tick(1); drain("fo_return");
        hb2_run = 1'b1;
        push("sel", 0); push("busy", 0);
        tick(20); drain("fo_return_done");

        // ---- auto refuses a dead target, then both dead
        bus.req_clk1 = 1'b1;
        push("sel", 1); push("busy", 1); push("fo", 0);
        tick(1); drain("ref_to_clk1");
        tick(20);
        hb2_run = 1'b0;
        push("ok2", 0); push("sel", 1); push("busy", 0); push("bd", 0);
        tick(75); drain("ref_clk2_dead");
        bus.req_clk1 = 1'b0;
        push("sel", 1); push("busy", 0); push("fo", 0);
        tick(3); drain("ref_refuse");
        hb1_run = 1'b0;
        push("ok1", 0); push("bd", 1); push("sel", 1); push("busy", 0);
        tick(75); drain("both_dead");
        bus.auto_en = 1'b0;
        push("sel", 0); push("busy", 1); push("fo", 0); push("bd", 1);
        tick(1); drain("bd_manual");

        // ---- reset in the middle of a hold
        push("sel", 0); push("busy", 1);
        tick(7); drain("pre_rst_hold");
        rst = 1'b1;
        #1;
        push("sel", 1); push("busy", 0); push("fo", 0);
        drain("rst_mid_hold");
        bus.req_clk1 = 1'b1;
        hb1_run = 1'b1;
        hb2_run = 1'b1;
        tick(3);
        rst = 1'b0;
        push("sel", 1); push("busy", 0); push("ok1", 1); push("ok2", 1); push("bd", 0);
        tick(6); drain("post_rst");
        // an immediate switch shows the FSM left reset in S_CLK1, not in hold
        bus.req_clk1 = 1'b0;
        push("sel", 0); push("busy", 1); push("fo", 0);
        tick(1); drain("post_rst_switch");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
